eb_skp_ctrl: RTL and testbench
==============================

# eb_skp_ctrl

Read-side controller for the PCIe RX elastic buffer. It runs in the recovered-read clock domain and owns the read pointer. It converts the synchronized Gray write pointer to a fill level and sequences reads. It compensates clock drift by inserting or deleting one SKP symbol per SKP ordered set, and detects underflow and overflow and recovers from them.

## Interface
Parameters:
- PTR_WIDTH, 4: pointer width including wrap bit. Buffer depth is DEPTH = 2^(PTR_WIDTH-1) = 8.
- HI_THRESH, 6: fill above this value requests a SKP delete.
- LO_THRESH, 2: fill below this value requests a SKP insert.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_ptr_gray_sync  in  PTR_WIDTH  write pointer, Gray-coded, already passed through the 2-flop synchronizer.
- rd_req  in  1  downstream requests one symbol this cycle.
- skp_at_head  in  1  symbol at rd_ptr is a SKP symbol inside a SKP OS.
- clr_err  in  1  clears the sticky error flags.
- rd_ptr  out  PTR_WIDTH  binary read pointer; its low PTR_WIDTH-1 bits address the RAM.
- rd_valid  out  1  the symbol presented this cycle is valid.
- skp_insert  out  1  the datapath substitutes a SKP symbol; rd_ptr held.
- skp_delete  out  1  the SKP symbol at the old rd_ptr is discarded.
- fill_level  out  PTR_WIDTH  current occupancy, 0..DEPTH.
- underflow  out  1  sticky flag.
- overflow  out  1  sticky flag.

## Operation
- wr_bin_q is a register holding gray2bin(wr_ptr_gray_sync).
- fill = (wr_bin_q - rd_ptr) mod 2^PTR_WIDTH, computed combinationally from registers. fill_level = fill.
- States:
  - INIT_FILL: no reads. Go to RUN when fill >= DEPTH/2.
  - RUN: normal reads.
  - RESYNC: one cycle. rd_ptr <= wr_bin_q - DEPTH/2. Then go to RUN.
- Per-cycle priority in RUN, highest first:
  1. fill == DEPTH: set overflow, go to RESYNC.
  2. rd_req and fill == 0: set underflow, go to INIT_FILL. No read.
  3. rd_req, skp_at_head, !adj_done, fill < LO_THRESH: skp_insert. rd_ptr holds. Set adj_done.
  4. rd_req, skp_at_head, !adj_done, fill > HI_THRESH: skp_delete. rd_ptr += 1. Set adj_done.
  5. rd_req: normal read, rd_ptr += 1.
- adj_done clears on any cycle with skp_at_head == 0. This limits compensation to one insert or delete per SKP OS.
- Overflow is also checked in INIT_FILL. RESYNC ignores rd_req.
- clr_err clears both sticky flags. If a flag is set in the same cycle as clr_err, the set wins.
- rd_ptr increments wrap modulo 2^PTR_WIDTH. All pointer subtraction is PTR_WIDTH-bit unsigned.

## Timing
- Reset values:
  - rd_ptr 0, wr_bin_q 0, fill_level 0.
  - rd_valid, skp_insert, skp_delete, underflow, overflow, adj_done all 0.
  - State INIT_FILL.
- Latency from wr_ptr_gray_sync to fill_level: 1 cycle.
- rd_valid, skp_insert and skp_delete are registered. They assert in the cycle after rd_req is sampled, for exactly 1 cycle per accepted request.
- Output combinations:
  - skp_insert implies rd_valid = 1.
  - skp_delete implies rd_valid = 0.
  - skp_insert and skp_delete are mutually exclusive.
- rd_ptr updates on the same edge that registers rd_valid. The RAM address is therefore already advanced when rd_valid rises, so the datapath must register read data from the pre-edge address.
- Asserting rst mid-operation forces reset values immediately. After rst deasserts, the buffer refills through INIT_FILL.

## Structure
- Shared package eb_pkg:
  - eb_state_e enum {INIT_FILL, RUN, RESYNC}.
  - gray2bin function, parameterized by width.
  - DEPTH and HALF constants derived from PTR_WIDTH.
- No sub-module. Single module with one always_ff block for the state, pointer and flags, and one always_comb block for the next-state and decision logic.
- The 2-flop write-pointer synchronizer is instantiated by the parent, not inside this block.

## Test plan
All cases use PTR_WIDTH=4, HI_THRESH=6, LO_THRESH=2.
- Initial fill: after reset, step wr_ptr_gray_sync through Gray 0,1,3,2,6 -> rd_valid stays 0 until fill_level=4. The first rd_req then gives rd_valid=1 on the next cycle and rd_ptr 0->1.
- Insert: fill=1, skp_at_head=1 held 3 cycles, rd_req=1 -> exactly one skp_insert with rd_ptr unchanged, then normal reads while skp_at_head stays high.
- Delete: fill=7, skp_at_head=1, rd_req=1 -> skp_delete=1, rd_valid=0, rd_ptr+1, fill_level=6. A second SKP OS after skp_at_head drops may delete again.
- Underflow: freeze writes and drain to fill=0, then rd_req=1 -> underflow=1, rd_valid=0, state INIT_FILL. clr_err clears the flag; asserting clr_err together with a new underflow leaves it 1.
- Overflow: writes advance to fill=8 -> overflow=1, RESYNC, then fill_level=4 the following cycle.
- Wrap and reset: rd_ptr=15, wr_bin_q=2 -> fill_level=3, and a read wraps rd_ptr to 0. Pulse rst mid-read -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/eb_pkg.sv
// Shared types and helpers for the RX elastic-buffer read-side controller.
package eb_pkg;

  typedef enum logic [1:0] {
    INIT_FILL = 2'd0,
    RUN       = 2'd1,
    RESYNC    = 2'd2
  } eb_state_e;

  localparam int EB_PTR_WIDTH = 4;
  localparam int DEPTH        = 2 ** (EB_PTR_WIDTH - 1);
  localparam int HALF         = DEPTH / 2;

  function automatic int unsigned eb_depth(input int ptr_width);
    return 2 ** (ptr_width - 1);
  endfunction

  // Prefix-XOR from the MSB down; bits at or above width come out as zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
    logic [31:0] bin;
    logic        acc;
    bin = '0;
    acc = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (i < width) begin
        acc    = acc ^ gray[i];
        bin[i] = acc;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/eb_skp_ctrl.sv
// Read-side controller of the PCIe RX elastic buffer: owns rd_ptr, tracks fill,
// adds/drops one SKP per ordered set for drift, and recovers from under/overflow.
//
// state     | meaning
// INIT_FILL | no reads; wait for the buffer to reach half full
// RUN       | normal reads with SKP insert/delete compensation
// RESYNC    | one cycle; re-centre rd_ptr half a buffer behind the writer
module eb_skp_ctrl
  import eb_pkg::*;
#(
  parameter int PTR_WIDTH = EB_PTR_WIDTH,
  parameter int HI_THRESH = DEPTH - 2,
  parameter int LO_THRESH = HALF / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PTR_WIDTH-1:0] wr_ptr_gray_sync,
  input  logic                 rd_req,
  input  logic                 skp_at_head,
  input  logic                 clr_err,
  output logic [PTR_WIDTH-1:0] rd_ptr,
  output logic                 rd_valid,
  output logic                 skp_insert,
  output logic                 skp_delete,
  output logic [PTR_WIDTH-1:0] fill_level,
  output logic                 underflow,
  output logic                 overflow
);

  localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(eb_depth(PTR_WIDTH));
  localparam logic [PTR_WIDTH-1:0] HALF_P  = PTR_WIDTH'(eb_depth(PTR_WIDTH) / 2);
  localparam logic [PTR_WIDTH-1:0] HI_P    = PTR_WIDTH'(HI_THRESH);
  localparam logic [PTR_WIDTH-1:0] LO_P    = PTR_WIDTH'(LO_THRESH);

  eb_state_e            state_q, state_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_bin_q, wr_bin_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 skp_insert_q, skp_insert_d;
  logic                 skp_delete_q, skp_delete_d;
  logic                 underflow_q, underflow_d;
  logic                 overflow_q, overflow_d;
  logic                 adj_done_q, adj_done_d;

  logic [PTR_WIDTH-1:0] fill;
  logic                 set_uf;
  logic                 set_of;

  // Modulo subtraction gives the true occupancy 0..DEPTH thanks to the wrap bit.
  assign fill = wr_bin_q - rd_ptr_q;

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_bin_d     = PTR_WIDTH'(gray2bin(32'(wr_ptr_gray_sync), PTR_WIDTH));
    rd_valid_d   = 1'b0;
    skp_insert_d = 1'b0;
    skp_delete_d = 1'b0;
    adj_done_d   = adj_done_q & skp_at_head;
    set_uf       = 1'b0;
    set_of       = 1'b0;

    case (state_q)
      INIT_FILL: begin
        if (fill == DEPTH_P) begin
          set_of  = 1'b1;
          state_d = RESYNC;
        end else if (fill >= HALF_P) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (fill == DEPTH_P) begin
          set_of  = 1'b1;
          state_d = RESYNC;
        end else if (rd_req && fill == '0) begin
          set_uf  = 1'b1;
          state_d = INIT_FILL;
        end else if (rd_req && skp_at_head && !adj_done_q && fill < LO_P) begin
          // Replay a SKP without consuming: the datapath substitutes it.
          skp_insert_d = 1'b1;
          rd_valid_d   = 1'b1;
          adj_done_d   = 1'b1;
        end else if (rd_req && skp_at_head && !adj_done_q && fill > HI_P) begin
          skp_delete_d = 1'b1;
          rd_ptr_d     = rd_ptr_q + 1'b1;
          adj_done_d   = 1'b1;
        end else if (rd_req) begin
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
        end
      end

      RESYNC: begin
        rd_ptr_d = wr_bin_q - HALF_P;
        state_d  = RUN;
      end

      default: state_d = INIT_FILL;
    endcase

    underflow_d = (underflow_q & ~clr_err) | set_uf;
    overflow_d  = (overflow_q & ~clr_err) | set_of;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT_FILL;
      rd_ptr_q     <= '0;
      wr_bin_q     <= '0;
      rd_valid_q   <= 1'b0;
      skp_insert_q <= 1'b0;
      skp_delete_q <= 1'b0;
      underflow_q  <= 1'b0;
      overflow_q   <= 1'b0;
      adj_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_bin_q     <= wr_bin_d;
      rd_valid_q   <= rd_valid_d;
      skp_insert_q <= skp_insert_d;
      skp_delete_q <= skp_delete_d;
      underflow_q  <= underflow_d;
      overflow_q   <= overflow_d;
      adj_done_q   <= adj_done_d;
    end
  end

  assign rd_ptr     = rd_ptr_q;
  assign rd_valid   = rd_valid_q;
  assign skp_insert = skp_insert_q;
  assign skp_delete = skp_delete_q;
  assign fill_level = fill;
  assign underflow  = underflow_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_eb_skp_ctrl.sv
// Directed bench for eb_skp_ctrl with an integer-arithmetic reference model
// compared on every falling edge, plus hand-computed literal checkpoints.
module tb_eb_skp_ctrl;

  localparam int PW  = 4;
  localparam int MOD = 16;
  localparam int DEP = 8;
  localparam int HLF = 4;
  localparam int HI  = 6;
  localparam int LO  = 2;

  localparam int PH_FILL   = 0;
  localparam int PH_RUN    = 1;
  localparam int PH_RESYNC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] wr_ptr_gray_sync;
  logic          rd_req;
  logic          skp_at_head;
  logic          clr_err;
  logic [PW-1:0] rd_ptr;
  logic          rd_valid;
  logic          skp_insert;
  logic          skp_delete;
  logic [PW-1:0] fill_level;
  logic          underflow;
  logic          overflow;

  eb_skp_ctrl #(.PTR_WIDTH(PW), .HI_THRESH(HI), .LO_THRESH(LO)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_ptr_gray_sync (wr_ptr_gray_sync),
    .rd_req           (rd_req),
    .skp_at_head      (skp_at_head),
    .clr_err          (clr_err),
    .rd_ptr           (rd_ptr),
    .rd_valid         (rd_valid),
    .skp_insert       (skp_insert),
    .skp_delete       (skp_delete),
    .fill_level       (fill_level),
    .underflow        (underflow),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: plain integers for pointers, a phase number for mode.
  int m_rd, m_wr, m_phase;
  bit m_adj, m_uf, m_of, m_valid, m_ins, m_del;

  int glist[5] = '{0, 1, 3, 2, 6};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Find the binary count whose Gray code matches, rather than decoding bitwise.
  function automatic int g2b(input int g);
    for (int b = 0; b < MOD; b++)
      if (((b ^ (b >> 1)) % MOD) == g) return b;
    return 0;
  endfunction

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_phase = PH_FILL;
    m_adj = 0; m_uf = 0; m_of = 0; m_valid = 0; m_ins = 0; m_del = 0;
  endtask

  task automatic model_step();
    int fill, nrd, nph;
    bit adj, uf_set, of_set;
    fill = (m_wr - m_rd + MOD) % MOD;
    nrd = m_rd; nph = m_phase;
    uf_set = 0; of_set = 0;
    m_valid = 0; m_ins = 0; m_del = 0;
    adj = m_adj && skp_at_head;
    if (m_phase == PH_RESYNC) begin
      nrd = (m_wr - HLF + MOD) % MOD;
      nph = PH_RUN;
    end else if (fill == DEP) begin
      of_set = 1;
      nph = PH_RESYNC;
    end else if (m_phase == PH_FILL) begin
      if (fill >= HLF) nph = PH_RUN;
    end else if (rd_req) begin
      if (fill == 0) begin
        uf_set = 1;
        nph = PH_FILL;
      end else if (skp_at_head && !m_adj && fill < LO) begin
        m_ins = 1; m_valid = 1; adj = 1;
      end else if (skp_at_head && !m_adj && fill > HI) begin
        m_del = 1; adj = 1; nrd = (m_rd + 1) % MOD;
      end else begin
        m_valid = 1; nrd = (m_rd + 1) % MOD;
      end
    end
    m_uf = (m_uf && !clr_err) || uf_set;
    m_of = (m_of && !clr_err) || of_set;
    m_rd = nrd;
    m_phase = nph;
    m_adj = adj;
    m_wr = g2b(int'(wr_ptr_gray_sync));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic setw(input int b);
    wr_ptr_gray_sync = PW'(b ^ (b >> 1));
  endtask

  always @(negedge clk) begin
    check("cmp rd_ptr",     int'(rd_ptr),     m_rd);
    check("cmp fill_level", int'(fill_level), (m_wr - m_rd + MOD) % MOD);
    check("cmp rd_valid",   int'(rd_valid),   int'(m_valid));
    check("cmp skp_insert", int'(skp_insert), int'(m_ins));
    check("cmp skp_delete", int'(skp_delete), int'(m_del));
    check("cmp underflow",  int'(underflow),  int'(m_uf));
    check("cmp overflow",   int'(overflow),   int'(m_of));
  end

  initial begin
    rst = 1'b1; rd_req = 1'b0; skp_at_head = 1'b0; clr_err = 1'b0;
    wr_ptr_gray_sync = '0;
    model_reset();
    tick(); tick();
    check("reset rd_ptr", int'(rd_ptr), 0);
    check("reset fill", int'(fill_level), 0);
    check("reset rd_valid", int'(rd_valid), 0);
    check("reset flags", int'({underflow, overflow}), 0);
    rst = 1'b0;

    // Initial fill: no reads until half full
    for (int i = 0; i < 5; i++) begin
      wr_ptr_gray_sync = PW'(glist[i]);
      tick();
      check("init no read", int'(rd_valid), 0);
    end
    check("init fill 4", int'(fill_level), 4);
    tick();
    rd_req = 1'b1;
    tick();
    check("first read valid", int'(rd_valid), 1);
    check("first read ptr", int'(rd_ptr), 1);
    tick(); tick();
    check("drain to 1", int'(fill_level), 1);

    // Insert once per SKP OS
    skp_at_head = 1'b1;
    setw(6);
    tick();
    check("insert flag", int'(skp_insert), 1);
    check("insert valid", int'(rd_valid), 1);
    check("insert ptr held", int'(rd_ptr), 3);
    tick();
    check("insert once", int'(skp_insert), 0);
    check("post insert ptr", int'(rd_ptr), 4);
    tick();
    check("post insert ptr2", int'(rd_ptr), 5);
    skp_at_head = 1'b0; rd_req = 1'b0;
    tick();

    // Delete, blocked while same OS, allowed again on next OS
    setw(12);
    tick();
    check("fill 7", int'(fill_level), 7);
    skp_at_head = 1'b1; rd_req = 1'b1;
    tick();
    check("delete flag", int'(skp_delete), 1);
    check("delete valid", int'(rd_valid), 0);
    check("delete ptr", int'(rd_ptr), 6);
    check("delete fill", int'(fill_level), 6);
    setw(14);
    tick();
    tick();
    check("same OS no delete", int'(skp_delete), 0);
    check("same OS read", int'(rd_valid), 1);
    check("same OS ptr", int'(rd_ptr), 8);
    skp_at_head = 1'b0; rd_req = 1'b0;
    tick();
    setw(15);
    tick();
    skp_at_head = 1'b1; rd_req = 1'b1;
    tick();
    check("second OS delete", int'(skp_delete), 1);
    check("second OS ptr", int'(rd_ptr), 9);
    skp_at_head = 1'b0;

    // Underflow and clear
    repeat (6) tick();
    check("drained fill", int'(fill_level), 0);
    check("drained ptr", int'(rd_ptr), 15);
    tick();
    check("underflow set", int'(underflow), 1);
    check("underflow no read", int'(rd_valid), 0);
    rd_req = 1'b0; clr_err = 1'b1;
    tick();
    check("underflow cleared", int'(underflow), 0);
    clr_err = 1'b0;

    // Wrap: rd_ptr 15, writer at 2
    setw(2);
    tick();
    check("wrap fill 3", int'(fill_level), 3);
    setw(3);
    tick(); tick();
    rd_req = 1'b1;
    tick();
    check("wrap ptr 0", int'(rd_ptr), 0);
    check("wrap valid", int'(rd_valid), 1);
    tick(); tick(); tick();
    clr_err = 1'b1;
    tick();
    check("set beats clear", int'(underflow), 1);
    rd_req = 1'b0;
    tick();
    check("clear after", int'(underflow), 0);
    clr_err = 1'b0;

    // Overflow and resync
    setw(7);
    tick(); tick();
    setw(11);
    tick();
    check("full fill 8", int'(fill_level), 8);
    check("no overflow yet", int'(overflow), 0);
    rd_req = 1'b1;
    tick();
    check("overflow set", int'(overflow), 1);
    check("overflow no read", int'(rd_valid), 0);
    tick();
    check("resync fill 4", int'(fill_level), 4);
    check("resync ptr", int'(rd_ptr), 7);
    check("resync no read", int'(rd_valid), 0);

    // Asynchronous reset mid-read
    tick();
    check("pre reset valid", int'(rd_valid), 1);
    check("pre reset ptr", int'(rd_ptr), 8);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async rd_ptr", int'(rd_ptr), 0);
    check("async rd_valid", int'(rd_valid), 0);
    check("async fill", int'(fill_level), 0);
    check("async overflow", int'(overflow), 0);
    rd_req = 1'b0; wr_ptr_gray_sync = '0;
    tick();
    rst = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      setw(b);
      tick();
      check("refill no read", int'(rd_valid), 0);
    end
    tick();
    rd_req = 1'b1;
    tick();
    check("refill read", int'(rd_valid), 1);
    check("refill ptr", int'(rd_ptr), 1);
    rd_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
